seq_div_32by16: RTL

Sequential radix-2 restoring divider. It divides a 32-bit dividend by a 16-bit divisor and returns a 32-bit quotient and a 16-bit remainder. It is the inverse of the 16x16 partial-product multiplier in the arithmetic testcase set: feeding it a 32-bit product and one 16-bit operand recovers the other operand. One quotient bit is produced per clock, behind valid/ready handshakes on both input and output.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 29 ++
 rtl/seq_div_32by16.sv | 135 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    localparam int unsigned DIV_N_W = 32;
    localparam int unsigned DIV_D_W = 16;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division iteration.
module div_step #(
    parameter int unsigned N_W = 32,
    parameter int unsigned D_W = 16
) (
    input  logic [D_W:0]   r,
    input  logic [N_W-1:0] q,
    input  logic [D_W-1:0] divisor,
    output logic [D_W:0]   r_next,
    output logic [N_W-1:0] q_next
);

    logic [D_W:0] r_sh;
    logic [D_W:0] dvsr_ext;

    assign r_sh     = {r[D_W-1:0], q[N_W-1]};
    assign dvsr_ext = {1'b0, divisor};

    // The partial remainder stays below the divisor, so the D_W+1 bit shift never overflows.
    always_comb begin
        r_next = r_sh;
        q_next = {q[N_W-2:0], 1'b0};
        if (r_sh >= dvsr_ext) begin
            r_next    = r_sh - dvsr_ext;
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_div_32by16.sv
// Sequential unsigned divider producing one quotient bit per clock behind valid/ready handshakes.
module seq_div_32by16
    import div_pkg::*;
#(
    parameter int unsigned N_W = DIV_N_W,
    parameter int unsigned D_W = DIV_D_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero
);

    localparam int unsigned CNT_W = $clog2(N_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_W - 1);

    div_state_t state_q, state_d;

    logic [D_W:0]     r_q, r_d;
    logic [N_W-1:0]   q_q, q_d;
    logic [D_W-1:0]   dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [D_W:0]     step_r;
    logic [N_W-1:0]   step_q;
    logic             accept;
    logic             divisor_zero;

    assign accept       = in_valid & in_ready;
    assign divisor_zero = (divisor == '0);

    div_step #(
        .N_W (N_W),
        .D_W (D_W)
    ) u_step (
        .r       (r_q),
        .q       (q_q),
        .divisor (dvsr_q),
        .r_next  (step_r),
        .q_next  (step_q)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = divisor_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next state: load on accept, iterate in BUSY, hold otherwise.
    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        dbz_d  = dbz_q;
        if (accept) begin
            dvsr_d = divisor;
            cnt_d  = '0;
            if (divisor_zero) begin
                r_d   = {1'b0, dividend[D_W-1:0]};
                q_d   = '1;
                dbz_d = 1'b1;
            end else begin
                r_d   = '0;
                q_d   = dividend;
                dbz_d = 1'b0;
            end
        end else if (state_q == BUSY) begin
            r_d   = step_r;
            q_d   = step_q;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            q_q    <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = q_q;
    assign remainder   = r_q[D_W-1:0];
    assign div_by_zero = dbz_q;

endmodule
